// File: rtl/elastic_buffer.sv
// elastic_buffer: DEPTH-entry, WIDTH-bit valid/ready elastic buffer.
// Storage is a circular array addressed by explicitly wrapping read/write
// pointers, plus an occupancy counter. Every output is derived from
// registered state only, so no input reaches an output combinationally.
// A word written in one cycle is first visible on the output in the next cycle.
module elastic_buffer #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             vld_out,
  input  logic             rdy_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             almost_full
);

  // Pointer width is at least one bit. This keeps the declarations legal for any DEPTH.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] wrPtr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic push;
  logic pop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A transfer happens on a side only when both valid and ready are high on that side.
  always_comb begin
    push = vld_in && rdy_out;
    pop  = vld_out && rdy_in;
  end

  // Next-state logic. Flush empties the buffer and discards any push or pop in the same cycle.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = nextPtr(wrPtr_q);
      end
      if (pop) begin
        rdPtr_d = nextPtr(rdPtr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register. Synchronous reset has priority over flush and traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage write. The array is never reset; a write is blocked while reset or flush is active.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  // Outputs depend only on registered state. This makes rdy_out independent of rdy_in.
  always_comb begin
    rdy_out     = (count_q != FULL_CNT);
    vld_out     = (count_q != '0);
    data_out    = mem_q[rdPtr_q];
    count       = count_q;
    almost_full = (count_q >= AFULL_CNT);
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// tb_elastic_buffer: testbench for elastic_buffer.
// It instantiates two DUTs with WIDTH=16: DEPTH=4 and DEPTH=3, the second being
// a non-power-of-two depth. A queue-per-DUT reference model predicts count,
// flags and head data every cycle. Directed phases add explicit constant checks.
module tb_elastic_buffer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  logic         vldIn4, rdyIn4, rdyOut4, vldOut4, almostFull4;
  logic [W-1:0] dataIn4, dataOut4;
  logic [2:0]   count4;

  logic         vldIn3, rdyIn3, rdyOut3, vldOut3, almostFull3;
  logic [W-1:0] dataIn3, dataOut3;
  logic [1:0]   count3;

  elastic_buffer #(.WIDTH(W), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush),
    .vld_in(vldIn4), .rdy_out(rdyOut4), .data_in(dataIn4),
    .vld_out(vldOut4), .rdy_in(rdyIn4), .data_out(dataOut4),
    .count(count4), .almost_full(almostFull4)
  );

  elastic_buffer #(.WIDTH(W), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush),
    .vld_in(vldIn3), .rdy_out(rdyOut3), .data_in(dataIn3),
    .vld_out(vldOut3), .rdy_in(rdyIn3), .data_out(dataOut3),
    .count(count3), .almost_full(almostFull3)
  );

  int compareCount = 0;
  int errorCount   = 0;
  int cycleNo      = 0;
  int popped3      = 0;

  logic [W-1:0] q4[$];
  logic [W-1:0] q3[$];
  bit push4, pop4, push3, pop3;

  // This task is the single comparison point. It counts each comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s (cycle %0d): actual=0x%0h expected=0x%0h", tag, cycleNo, actual, expected);
    end
  endtask

  // This task advances one clock cycle. It checks both DUTs against the queue models at the
  // negative edge. It then decides which transfers the models accept and updates the models at the edge.
  task automatic stepCycle();
    @(negedge clk);
    checkOutput("u4 count",       32'(count4),      32'(q4.size()));
    checkOutput("u4 vld_out",     32'(vldOut4),     32'(q4.size() != 0));
    checkOutput("u4 rdy_out",     32'(rdyOut4),     32'(q4.size() != 4));
    checkOutput("u4 almost_full", 32'(almostFull4), 32'(q4.size() >= 3));
    if (q4.size() != 0) checkOutput("u4 data_out", 32'(dataOut4), 32'(q4[0]));
    checkOutput("u3 count",       32'(count3),      32'(q3.size()));
    checkOutput("u3 vld_out",     32'(vldOut3),     32'(q3.size() != 0));
    checkOutput("u3 rdy_out",     32'(rdyOut3),     32'(q3.size() != 3));
    checkOutput("u3 almost_full", 32'(almostFull3), 32'(q3.size() >= 2));
    if (q3.size() != 0) checkOutput("u3 data_out", 32'(dataOut3), 32'(q3[0]));
    push4 = vldIn4 && (q4.size() < 4);
    pop4  = rdyIn4 && (q4.size() > 0);
    push3 = vldIn3 && (q3.size() < 3);
    pop3  = rdyIn3 && (q3.size() > 0);
    @(posedge clk);
    if (rst || flush) begin
      q4.delete();
      q3.delete();
      push4 = 0; pop4 = 0; push3 = 0; pop3 = 0;
    end else begin
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(dataIn4);
      if (pop3) begin
        void'(q3.pop_front());
        popped3++;
      end
      if (push3) q3.push_back(dataIn3);
    end
    cycleNo++;
    #1;
  endtask

  // This task generates random stimulus for both DUTs. A valid word that was not accepted
  // is held unchanged, so the upstream protocol is respected.
  task automatic applyStimulus();
    if (!(vldIn4 && !push4)) begin
      vldIn4  = 1'($urandom_range(0, 1));
      dataIn4 = 16'($urandom);
    end
    rdyIn4 = 1'($urandom_range(0, 1));
    if (!(vldIn3 && !push3)) begin
      vldIn3  = 1'($urandom_range(0, 1));
      dataIn3 = 16'($urandom);
    end
    rdyIn3 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    vldIn4 = 0; rdyIn4 = 0; dataIn4 = '0;
    vldIn3 = 0; rdyIn3 = 0; dataIn3 = '0;
    repeat (2) @(posedge clk);
    #1;

    // The first phase checks the reset state while rst is still high.
    checkOutput("reset u4 count",       32'(count4),      32'd0);
    checkOutput("reset u4 vld_out",     32'(vldOut4),     32'd0);
    checkOutput("reset u4 rdy_out",     32'(rdyOut4),     32'd1);
    checkOutput("reset u4 almost_full", 32'(almostFull4), 32'd0);
    checkOutput("reset u3 count",       32'(count3),      32'd0);
    checkOutput("reset u3 rdy_out",     32'(rdyOut3),     32'd1);
    rst = 1'b0;

    // The next phase fills u4 with downstream stalled. It then holds word 0x0005, which must be refused.
    for (int i = 1; i <= 4; i++) begin
      vldIn4 = 1'b1; dataIn4 = 16'(i);
      stepCycle();
      checkOutput("fill count", 32'(count4), 32'(i));
      checkOutput("fill almost_full", 32'(almostFull4), 32'(i >= 3));
    end
    checkOutput("full rdy_out", 32'(rdyOut4), 32'd0);
    dataIn4 = 16'h0005;
    repeat (2) stepCycle();
    checkOutput("full hold count", 32'(count4), 32'd4);
    vldIn4 = 1'b0;

    // The next phase drains u4 and checks that words leave in order.
    rdyIn4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain head", 32'(dataOut4), 32'(i));
      stepCycle();
      checkOutput("drain count", 32'(count4), 32'(4 - i));
      if (i == 1) checkOutput("rdy after first pop", 32'(rdyOut4), 32'd1);
    end
    checkOutput("drained vld_out", 32'(vldOut4), 32'd0);

    // The next phase streams 20 words with one push and one pop per cycle. The pointers wrap 5 times.
    vldIn4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dataIn4 = 16'(16'h0100 + i);
      stepCycle();
      checkOutput("stream count", 32'(count4), 32'd1);
      checkOutput("stream head", 32'(dataOut4), 32'(16'h0100 + i));
    end
    vldIn4 = 1'b0;
    stepCycle();
    checkOutput("stream end vld_out", 32'(vldOut4), 32'd0);
    rdyIn4 = 1'b0;

    // The next phase loads 3 words and then flushes while a push and a pop are both presented.
    vldIn4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dataIn4 = 16'(16'h00A0 + i);
      stepCycle();
    end
    flush = 1'b1; dataIn4 = 16'h5555; rdyIn4 = 1'b1;
    stepCycle();
    flush = 1'b0; vldIn4 = 1'b0; rdyIn4 = 1'b0;
    checkOutput("flush count", 32'(count4), 32'd0);
    checkOutput("flush vld_out", 32'(vldOut4), 32'd0);
    checkOutput("flush rdy_out", 32'(rdyOut4), 32'd1);
    vldIn4 = 1'b1; dataIn4 = 16'hBEEF;
    stepCycle();
    vldIn4 = 1'b0;
    checkOutput("post-flush head", 32'(dataOut4), 32'h0000BEEF);
    checkOutput("post-flush count", 32'(count4), 32'd1);
    rdyIn4 = 1'b1;
    stepCycle();
    rdyIn4 = 1'b0;

    // The next phase asserts reset mid-stream with two words held. It then checks that the buffer restarts with a fresh order.
    vldIn4 = 1'b1;
    dataIn4 = 16'h00C1; stepCycle();
    dataIn4 = 16'h00C2; stepCycle();
    vldIn4 = 1'b0;
    checkOutput("pre-reset count", 32'(count4), 32'd2);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("mid reset count", 32'(count4), 32'd0);
    checkOutput("mid reset vld_out", 32'(vldOut4), 32'd0);
    checkOutput("mid reset rdy_out", 32'(rdyOut4), 32'd1);
    checkOutput("mid reset almost_full", 32'(almostFull4), 32'd0);
    vldIn4 = 1'b1;
    dataIn4 = 16'h00D1; stepCycle();
    dataIn4 = 16'h00D2; stepCycle();
    vldIn4 = 1'b0;
    checkOutput("restart head", 32'(dataOut4), 32'h000000D1);
    rdyIn4 = 1'b1;
    repeat (2) stepCycle();
    rdyIn4 = 1'b0;
    checkOutput("restart drained", 32'(vldOut4), 32'd0);

    // The final phase drives random traffic on both DUTs until u3 has delivered 1000 words or the cycle budget runs out.
    popped3 = 0;
    push4 = 0; push3 = 0;
    for (int guard = 0; guard < 20000 && popped3 < 1000; guard++) begin
      applyStimulus();
      stepCycle();
    end
    checkOutput("u3 random words delivered", 32'(popped3), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
